// File: rtl/alu_dec_if.sv
// Decoder-side bundle between the main control unit, the ALU control decoder
// and the ALU: qualified ALUOp/funct in, ALU control code and status out.
interface alu_dec_if;
  logic       in_valid;
  logic [1:0] aluop;
  logic [5:0] funct;
  logic [2:0] alucontrol;
  logic       out_valid;
  logic       illegal;
  logic       err_sticky;

  modport master (
    output in_valid, aluop, funct,
    input  alucontrol, out_valid, illegal, err_sticky
  );

  modport slave (
    input  in_valid, aluop, funct,
    output alucontrol, out_valid, illegal, err_sticky
  );
endinterface

// File: rtl/alu_dec.sv
// MIPS ALU control decoder: ALUOp + R-type funct -> 3-bit ALU control code,
// optionally registered, with an illegal-funct flag and a sticky error bit.
module alu_dec #(
  parameter bit REGISTER_OUT = 1'b1
) (
  input  logic    clk,
  input  logic    rst,
  alu_dec_if.slave bus
);

  localparam logic [2:0] CTRL_AND = 3'b000;
  localparam logic [2:0] CTRL_OR  = 3'b001;
  localparam logic [2:0] CTRL_ADD = 3'b010;
  localparam logic [2:0] CTRL_SUB = 3'b110;
  localparam logic [2:0] CTRL_SLT = 3'b111;

  logic [2:0] ctrl_d;
  logic       illegal_d;
  logic       err_sticky_q;

  // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    ctrl_d    = CTRL_ADD;
    illegal_d = 1'b0;
    // aluop[0] is tested first so an unknown aluop[1] cannot disturb a beq decode.
    if (bus.aluop[0]) begin
      ctrl_d = CTRL_SUB;
    end else if (bus.aluop[1]) begin
      case (bus.funct)
        6'b100000: ctrl_d = CTRL_ADD;
        6'b100010: ctrl_d = CTRL_SUB;
        6'b100100: ctrl_d = CTRL_AND;
        6'b100101: ctrl_d = CTRL_OR;
        6'b101010: ctrl_d = CTRL_SLT;
        default:   illegal_d = 1'b1;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky_q <= 1'b0;
    end else if (bus.in_valid && illegal_d) begin
      err_sticky_q <= 1'b1;
    end
  end

  assign bus.err_sticky = err_sticky_q;

  generate
    if (REGISTER_OUT) begin : g_reg
      logic [2:0] ctrl_q;
      logic       illegal_q;
      logic       valid_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ctrl_q    <= CTRL_ADD;
          illegal_q <= 1'b0;
          valid_q   <= 1'b0;
        end else begin
          valid_q <= bus.in_valid;
          if (bus.in_valid) begin
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
          end
        end
      end

      assign bus.alucontrol = ctrl_q;
      assign bus.illegal    = illegal_q;
      assign bus.out_valid  = valid_q;
    end else begin : g_comb
      assign bus.alucontrol = ctrl_d;
      assign bus.illegal    = illegal_d;
      assign bus.out_valid  = bus.in_valid & ~rst;
    end
  endgenerate

endmodule

// File: tb/tb_alu_dec.sv
// Self-checking bench for alu_dec: registered and combinational instances
// driven in lockstep and compared against a table-driven reference model.
module tb_alu_dec;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_dec_if reg_if ();
  alu_dec_if comb_if ();

  alu_dec #(.REGISTER_OUT(1'b1)) u_reg (
    .clk (clk),
    .rst (rst),
    .bus (reg_if)
  );

  alu_dec #(.REGISTER_OUT(1'b0)) u_comb (
    .clk (clk),
    .rst (rst),
    .bus (comb_if)
  );

  int checks = 0;
  int errors = 0;

  // Expected state of the registered instance; err_sticky is shared by both.
  logic [2:0] m_ctrl;
  logic       m_ill;
  logic       m_ov;
  logic       m_sticky;

  logic [2:0] rtype_tbl [int];
  logic [5:0] legal_funct [5];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns {illegal, alucontrol} straight from the decode table.
  function automatic logic [3:0] ref_decode(input logic [1:0] op, input logic [5:0] fn);
    if (op[0] === 1'b1) return {1'b0, 3'b110};
    if (op === 2'b00)   return {1'b0, 3'b010};
    if (rtype_tbl.exists(int'(fn))) return {1'b0, rtype_tbl[int'(fn)]};
    return {1'b1, 3'b010};
  endfunction

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn);
    reg_if.in_valid  = v;
    reg_if.aluop     = op;
    reg_if.funct     = fn;
    comb_if.in_valid = v;
    comb_if.aluop    = op;
    comb_if.funct    = fn;
  endtask

  task automatic check_reg(input string tag);
    check({tag, "/r_ctrl"},   {5'd0, reg_if.alucontrol}, {5'd0, m_ctrl});
    check({tag, "/r_ill"},    {7'd0, reg_if.illegal},    {7'd0, m_ill});
    check({tag, "/r_ov"},     {7'd0, reg_if.out_valid},  {7'd0, m_ov});
    check({tag, "/r_sticky"}, {7'd0, reg_if.err_sticky}, {7'd0, m_sticky});
    check({tag, "/c_sticky"}, {7'd0, comb_if.err_sticky}, {7'd0, m_sticky});
  endtask

  // One transaction: combinational outputs checked before the edge, registered after it.
  task automatic step(input logic v, input logic [1:0] op, input logic [5:0] fn, input string tag);
    logic [3:0] d;
    @(negedge clk);
    drive(v, op, fn);
    d = ref_decode(op, fn);
    #1;
    check({tag, "/c_ov"}, {7'd0, comb_if.out_valid}, {7'd0, v});
    if (v) begin
      check({tag, "/c_ctrl"}, {5'd0, comb_if.alucontrol}, {5'd0, d[2:0]});
      check({tag, "/c_ill"},  {7'd0, comb_if.illegal},    {7'd0, d[3]});
    end
    @(posedge clk);
    #1;
    m_ov = v;
    if (v) begin
      m_ctrl   = d[2:0];
      m_ill    = d[3];
      m_sticky = m_sticky | d[3];
    end
    check_reg(tag);
  endtask

  task automatic model_reset();
    m_ctrl   = 3'b010;
    m_ill    = 1'b0;
    m_ov     = 1'b0;
    m_sticky = 1'b0;
  endtask

  initial begin
    logic       v;
    logic [1:0] op;
    logic [5:0] fn;

    rtype_tbl[32'h20] = 3'b010;
    rtype_tbl[32'h22] = 3'b110;
    rtype_tbl[32'h24] = 3'b000;
    rtype_tbl[32'h25] = 3'b001;
    rtype_tbl[32'h2a] = 3'b111;
    legal_funct = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

    rst = 1'b1;
    drive(1'b0, 2'b00, 6'd0);
    model_reset();
    #12;
    check_reg("reset");
    @(negedge clk);
    rst = 1'b0;

    // T1 add then sub
    step(1'b1, 2'b10, 6'b100000, "t1_add");
    step(1'b1, 2'b10, 6'b100010, "t1_sub");
    // T2 beq decodes with funct / aluop[1] unknown
    step(1'b1, 2'b01, 6'bxxxxxx, "t2_op01");
    step(1'b1, 2'b11, 6'bxxxxxx, "t2_op11");
    step(1'b1, 2'bx1, 6'bxxxxxx, "t2_opx1");
    // T3 memory/immediate add
    step(1'b1, 2'b00, 6'bxxxxxx, "t3_op00");
    // T4 back-to-back R-type
    step(1'b1, 2'b10, 6'b100100, "t4_and");
    step(1'b1, 2'b10, 6'b100101, "t4_or");
    step(1'b1, 2'b10, 6'b101010, "t4_slt");
    // Unknown inputs while idle must leave all state alone
    step(1'b0, 2'bxx, 6'bxxxxxx, "idle_x");
    step(1'b0, 2'b10, 6'b000000, "idle_ill");
    // T5 illegal funct, then a legal op keeps the sticky bit
    step(1'b1, 2'b10, 6'b000000, "t5_ill");
    step(1'b1, 2'b10, 6'b100010, "t5_after");

    // T6 asynchronous reset mid-stream
    step(1'b1, 2'b10, 6'b111111, "t6_pre");
    @(negedge clk);
    drive(1'b1, 2'b10, 6'b100010);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_reg("t6_async");
    check("t6_async/c_ov", {7'd0, comb_if.out_valid}, 8'd0);
    @(negedge clk);
    drive(1'b0, 2'b00, 6'd0);
    rst = 1'b0;
    step(1'b1, 2'b10, 6'b101010, "t6_first");

    // Randomized traffic, legal functs favoured
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      op = 2'($urandom);
      fn = ($urandom_range(0, 2) != 0) ? legal_funct[$urandom_range(0, 4)] : 6'($urandom);
      step(v, op, fn, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
